pipeline_power_ctrl: RTL and testbench
======================================

Name: pipeline_power_ctrl

Overview:
- Generates the per-stage enables (fetch/decode/execute) that the RISC-V pipeline consumes.
- Powers the stages up in pipeline order and drains them in the same order.
- Gates all stages when idle and drops into a deep-sleep state after a programmable idle period.
- Sits beside riscv_pipeline; its enable outputs connect 1:1 to the pipeline's enable_* inputs.

Parameters:
- STAGE_GAP, 1, cycles between successive stage enable edges during wake and drain (>=1)
- POWERUP_CYCLES, 4, cycles spent in POWERUP when leaving SLEEP (>=1)
- IDLE_TO_SLEEP, 16, consecutive IDLE cycles with run_req=0 before entering SLEEP (>=1)
- CNT_W, 32, width of the gated_cycles profiling counter

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; forces reset values immediately
- run_req  input  1  level request for the pipeline to run
- enable_fetch  output  1  to pipeline fetch stage
- enable_decode  output  1  to pipeline decode stage
- enable_execute  output  1  to pipeline execute/write-back
- sleep  output  1  deep-sleep indicator (retention/gating hint)
- ready  output  1  high only in RUN (all stages enabled)
- state_o  output  3  current FSM state encoding
- gated_cycles  output  CNT_W  count of cycles not in RUN, saturating

Behaviour:
- All outputs are registered.
- Reset values: state=SLEEP, all enables 0, sleep=1, ready=0, gated_cycles=0, internal counters 0.
- States are SLEEP(0), POWERUP(1), WAKE(2), RUN(3), DRAIN(4), IDLE(5). Codes 6–7 are illegal and recover to SLEEP on the next edge.
- SLEEP:
  - Enables 0, sleep=1.
  - run_req=1 sampled -> POWERUP; sleep drops on the same edge.
- POWERUP:
  - Enables 0, sleep=0.
  - Stays exactly POWERUP_CYCLES cycles, then -> WAKE.
  - If run_req=0 on the final cycle -> IDLE instead.
  - run_req=0 on earlier cycles does not abort.
- WAKE:
  - Step counter k counts from 0.
  - enable_fetch=1 from the entry edge.
  - enable_decode=1 from k=STAGE_GAP.
  - At k=2*STAGE_GAP-1 -> RUN; enable_execute asserts on that same edge.
  - run_req=0 in WAKE -> DRAIN with the current enables held as the starting point.
- RUN:
  - All enables 1, ready=1.
  - run_req=0 -> DRAIN; ready drops and enable_fetch drops on that edge.
- DRAIN:
  - enable_decode stays at its prior value until k=STAGE_GAP, then 0.
  - enable_execute stays at its prior value until k=2*STAGE_GAP, then 0 and -> IDLE.
  - An enable that was 0 on entry never rises in DRAIN.
  - run_req is ignored in DRAIN; drain always completes.
- IDLE:
  - Enables 0, sleep=0; idle counter increments each cycle.
  - run_req=1 -> WAKE, skipping POWERUP; idle counter cleared.
  - After IDLE_TO_SLEEP consecutive idle cycles -> SLEEP.
  - If run_req=1 and the sleep timeout occur on the same cycle, run_req wins.
- gated_cycles:
  - Increments every cycle state!=RUN.
  - Holds at all-ones (no wrap).
  - Cleared only by reset.
- Reset asserted mid-operation: outputs go to reset values asynchronously, with no drain sequencing.

Decomposition:
- Shared package pwr_ctrl_pkg holds:
  - the state enum/localparams (SLEEP..IDLE, 3-bit);
  - PWR_STATE_W=3;
  - default parameter constants.
- One natural sub-module: sat_counter (parameterised width, inc enable, saturate at max, async reset), used for gated_cycles.
- Step and idle counters stay inline.

Test Plan:
- Reset release, run_req=0 for 20 cycles -> state_o=0, sleep=1, all enables 0, gated_cycles=20.
- From SLEEP, run_req=1 held -> 4 POWERUP cycles, then:
  - enable_fetch rises at cycle t;
  - enable_decode at t+1;
  - enable_execute and ready at t+2;
  - state_o=3.
- In RUN, drop run_req at cycle u:
  - fetch=0 and ready=0 at u+1;
  - decode=0 at u+2;
  - execute=0 at u+3, state_o=5.
- IDLE timeout and IDLE wake:
  - run_req=0 in IDLE for 16 cycles -> state_o=0, sleep=1.
  - Re-raise run_req after 5 IDLE cycles instead -> enable_fetch on the next edge, no POWERUP.
- Abort and collisions:
  - Drop run_req at WAKE k=0 -> DRAIN; execute never pulses; IDLE after 2 cycles.
  - run_req pulses during DRAIN are ignored.
  - run_req=1 on the timeout cycle -> WAKE, not SLEEP.
- Reset and saturation:
  - Assert reset mid-RUN between clock edges -> all enables 0 and sleep=1 immediately.
  - With CNT_W=4, 20 non-RUN cycles -> gated_cycles=15 held.

Source files
------------

// File: rtl/pwr_ctrl_pkg.sv
// Shared definitions for the pipeline power controller.
//   - pwr_state_e : 3-bit FSM state encoding exposed on state_o
//   - DEF_*       : default parameter values used by pipeline_power_ctrl
package pwr_ctrl_pkg;

  localparam int PWR_STATE_W = 3;

  typedef enum logic [PWR_STATE_W-1:0] {
    ST_SLEEP   = 3'd0,
    ST_POWERUP = 3'd1,
    ST_WAKE    = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_IDLE    = 3'd5
  } pwr_state_e;

  localparam int DEF_STAGE_GAP      = 1;
  localparam int DEF_POWERUP_CYCLES = 4;
  localparam int DEF_IDLE_TO_SLEEP  = 16;
  localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
//   clk   : clock
//   reset : asynchronous clear to zero
//   inc   : count enable
//   count : current value, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_power_ctrl.sv
// Per-stage enable sequencer for the RISC-V pipeline. Powers fetch, decode
// and execute up in pipeline order, drains them in the same order, gates
// everything while idle and falls into deep sleep after an idle timeout.
//   clk            : system clock
//   reset          : asynchronous active-high reset
//   run_req        : level request for the pipeline to run
//   enable_fetch   : fetch stage enable
//   enable_decode  : decode stage enable
//   enable_execute : execute/write-back enable
//   sleep          : deep-sleep hint (retention/gating)
//   ready          : high only while all stages run
//   state_o        : current FSM state code
//   gated_cycles   : saturating count of cycles spent outside RUN
module pipeline_power_ctrl
  import pwr_ctrl_pkg::*;
#(
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int POWERUP_CYCLES = DEF_POWERUP_CYCLES,
  parameter int IDLE_TO_SLEEP  = DEF_IDLE_TO_SLEEP,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run_req,
  output logic                   enable_fetch,
  output logic                   enable_decode,
  output logic                   enable_execute,
  output logic                   sleep,
  output logic                   ready,
  output logic [PWR_STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]       gated_cycles
);

  localparam logic [31:0] PU_LAST   = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] GAP       = 32'(STAGE_GAP);
  localparam logic [31:0] SEQ_LAST  = 32'(2 * STAGE_GAP - 1);
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_TO_SLEEP - 1);

  pwr_state_e  state_q, state_d;
  logic [31:0] step_q, step_d, step_inc;
  logic [31:0] idle_q, idle_d;
  logic        fetch_d, decode_d, execute_d, sleep_d, ready_d;
  logic        gate_inc;

  assign step_inc = step_q + 32'd1;
  assign state_o  = state_q;
  assign gate_inc = (state_q != ST_RUN);

  // Next-state and next-output decode; every output is registered, so the
  // values computed here are what appears after the coming edge.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    idle_d    = idle_q;
    fetch_d   = 1'b0;
    decode_d  = 1'b0;
    execute_d = 1'b0;
    sleep_d   = 1'b0;
    ready_d   = 1'b0;
    case (state_q)
      ST_SLEEP: begin
        step_d = '0;
        idle_d = '0;
        if (run_req) begin
          state_d = ST_POWERUP;
        end else begin
          sleep_d = 1'b1;
        end
      end
      ST_POWERUP: begin
        // Only the run_req value on the final cycle decides where we go.
        if (step_q == PU_LAST) begin
          step_d = '0;
          idle_d = '0;
          if (run_req) begin
            state_d = ST_WAKE;
            fetch_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          step_d = step_inc;
        end
      end
      ST_WAKE: begin
        if (!run_req) begin
          // Drain starts from whatever is currently enabled.
          state_d   = ST_DRAIN;
          step_d    = '0;
          decode_d  = enable_decode;
          execute_d = enable_execute;
        end else if (step_q == SEQ_LAST) begin
          state_d   = ST_RUN;
          step_d    = '0;
          fetch_d   = 1'b1;
          decode_d  = 1'b1;
          execute_d = 1'b1;
          ready_d   = 1'b1;
        end else begin
          step_d   = step_inc;
          fetch_d  = 1'b1;
          decode_d = (step_inc >= GAP);
        end
      end
      ST_RUN: begin
        if (!run_req) begin
          state_d   = ST_DRAIN;
          step_d    = '0;
          decode_d  = 1'b1;
          execute_d = 1'b1;
        end else begin
          fetch_d   = 1'b1;
          decode_d  = 1'b1;
          execute_d = 1'b1;
          ready_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Enables can only fall here; holding the registered value keeps an
        // enable that entered low from ever rising.
        if (step_q == SEQ_LAST) begin
          state_d = ST_IDLE;
          step_d  = '0;
          idle_d  = '0;
        end else begin
          step_d    = step_inc;
          decode_d  = (step_inc >= GAP) ? 1'b0 : enable_decode;
          execute_d = enable_execute;
        end
      end
      ST_IDLE: begin
        // A wake request beats a coincident sleep timeout.
        if (run_req) begin
          state_d = ST_WAKE;
          step_d  = '0;
          idle_d  = '0;
          fetch_d = 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_SLEEP;
          idle_d  = '0;
          sleep_d = 1'b1;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      default: begin
        state_d = ST_SLEEP;
        step_d  = '0;
        idle_d  = '0;
        sleep_d = 1'b1;
      end
    endcase
  end

  // State and output register boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_SLEEP;
      step_q         <= '0;
      idle_q         <= '0;
      enable_fetch   <= 1'b0;
      enable_decode  <= 1'b0;
      enable_execute <= 1'b0;
      sleep          <= 1'b1;
      ready          <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      idle_q         <= idle_d;
      enable_fetch   <= fetch_d;
      enable_decode  <= decode_d;
      enable_execute <= execute_d;
      sleep          <= sleep_d;
      ready          <= ready_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_gated_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (gate_inc),
    .count(gated_cycles)
  );

endmodule

// File: tb/tb_pipeline_power_ctrl.sv
// Directed bench for pipeline_power_ctrl (default parameters) plus a 4-bit
// profiling-counter instance driven by the same stimulus for saturation.
module tb_pipeline_power_ctrl;

  logic        clk;
  logic        reset;
  logic        run_req;
  logic        en_f, en_d, en_e, slp, rdy;
  logic [2:0]  st;
  logic [31:0] gated;
  logic        en_f4, en_d4, en_e4, slp4, rdy4;
  logic [2:0]  st4;
  logic [3:0]  gated4;

  int checks = 0;
  int errors = 0;

  pipeline_power_ctrl dut (
    .clk(clk), .reset(reset), .run_req(run_req),
    .enable_fetch(en_f), .enable_decode(en_d), .enable_execute(en_e),
    .sleep(slp), .ready(rdy), .state_o(st), .gated_cycles(gated)
  );

  pipeline_power_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run_req(run_req),
    .enable_fetch(en_f4), .enable_decode(en_d4), .enable_execute(en_e4),
    .sleep(slp4), .ready(rdy4), .state_o(st4), .gated_cycles(gated4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full output snapshot: state, fetch, decode, execute, sleep, ready.
  task automatic chk_all(input string tag, input logic [2:0] s, input logic f,
                         input logic d, input logic e, input logic sl, input logic r);
    chk({tag, ".state"}, 32'(st), 32'(s));
    chk({tag, ".fetch"}, 32'(en_f), 32'(f));
    chk({tag, ".decode"}, 32'(en_d), 32'(d));
    chk({tag, ".execute"}, 32'(en_e), 32'(e));
    chk({tag, ".sleep"}, 32'(slp), 32'(sl));
    chk({tag, ".ready"}, 32'(rdy), 32'(r));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    run_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 3'd0, 0, 0, 0, 1, 0);
    chk("reset.gated", gated, 32'd0);
    reset = 1'b0;

    // 20 idle cycles in SLEEP
    step(20);
    chk_all("sleep20", 3'd0, 0, 0, 0, 1, 0);
    chk("sleep20.gated", gated, 32'd20);
    chk("sat.gated4", 32'(gated4), 32'd15);
    step(3);
    chk("sat.hold", 32'(gated4), 32'd15);
    chk("sleep23.gated", gated, 32'd23);

    // Power-up: 4 POWERUP cycles then staged wake
    run_req = 1'b1;
    step(1);
    chk_all("pu1", 3'd1, 0, 0, 0, 0, 0);
    step(3);
    chk_all("pu4", 3'd1, 0, 0, 0, 0, 0);
    step(1);
    chk_all("wake_t", 3'd2, 1, 0, 0, 0, 0);
    step(1);
    chk_all("wake_t1", 3'd2, 1, 1, 0, 0, 0);
    step(1);
    chk_all("run_t2", 3'd3, 1, 1, 1, 0, 1);
    chk("run.gated", gated, 32'd30);
    step(2);
    chk_all("run_hold", 3'd3, 1, 1, 1, 0, 1);
    chk("run_hold.gated", gated, 32'd30);

    // Drain from RUN
    run_req = 1'b0;
    step(1);
    chk_all("drain_u1", 3'd4, 0, 1, 1, 0, 0);
    step(1);
    chk_all("drain_u2", 3'd4, 0, 0, 1, 0, 0);
    step(1);
    chk_all("idle_u3", 3'd5, 0, 0, 0, 0, 0);

    // IDLE timeout after 16 cycles
    step(15);
    chk_all("idle15", 3'd5, 0, 0, 0, 0, 0);
    step(1);
    chk_all("timeout", 3'd0, 0, 0, 0, 1, 0);

    // Wake from SLEEP then abort at WAKE k=0
    run_req = 1'b1;
    step(5);
    chk_all("wake2", 3'd2, 1, 0, 0, 0, 0);
    run_req = 1'b0;
    step(1);
    chk_all("abort_d0", 3'd4, 0, 0, 0, 0, 0);
    step(1);
    chk_all("abort_d1", 3'd4, 0, 0, 0, 0, 0);
    step(1);
    chk_all("abort_idle", 3'd5, 0, 0, 0, 0, 0);

    // Re-raise run_req after 5 IDLE cycles: straight to WAKE
    step(4);
    chk("idle5.state", 32'(st), 32'd5);
    run_req = 1'b1;
    step(1);
    chk_all("idle_wake", 3'd2, 1, 0, 0, 0, 0);
    step(2);
    chk_all("run2", 3'd3, 1, 1, 1, 0, 1);

    // run_req pulse during DRAIN is ignored
    run_req = 1'b0;
    step(1);
    chk_all("drain2_0", 3'd4, 0, 1, 1, 0, 0);
    run_req = 1'b1;
    step(1);
    chk_all("drain2_1", 3'd4, 0, 0, 1, 0, 0);
    run_req = 1'b0;
    step(1);
    chk_all("drain2_idle", 3'd5, 0, 0, 0, 0, 0);

    // Wake request on the timeout cycle wins
    step(15);
    chk("coll.state", 32'(st), 32'd5);
    run_req = 1'b1;
    step(1);
    chk_all("coll_wake", 3'd2, 1, 0, 0, 0, 0);
    step(2);
    chk_all("run3", 3'd3, 1, 1, 1, 0, 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 0, 0, 0, 1, 0);
    chk("async_rst.gated", gated, 32'd0);
    chk("async_rst.gated4", 32'(gated4), 32'd0);
    step(1);
    reset   = 1'b0;
    run_req = 1'b0;
    step(2);
    chk_all("post_rst", 3'd0, 0, 0, 0, 1, 0);
    chk("post_rst.gated", gated, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
